wb_trace_monitor: RTL
=====================

Name: wb_trace_monitor

Overview:
Parametrised, synthesizable observer for the pipelined MIPS core. It attaches to the writeback-stage outputs (regWriteOut_WB, Destination_out_WB, writeData_WB) and the IF-stage PC (PC_out_reg_IF). It counts cycles and retired register writes, and logs the most recent writebacks in a circular buffer that can be read by index. It also detects a halted core (PC stuck). It replaces ad-hoc waveform inspection in the top-level benches and can be left in the FPGA build for debug read-back.

Parameters:
DATA_W, 32, width of writeback data and PC
REG_ADDR_W, 5, register destination address width
DEPTH, 16, trace buffer entries; power of two, minimum 2
CNT_W, 32, width of the cycle and retire counters
HALT_CYCLES, 4, consecutive cycles of unchanged PC that declare a halt; minimum 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
en  in  1  monitor enable; when 0, counters and buffer hold
clear  in  1  synchronous soft clear; same effect as rst
wb_we  in  1  writeback register-write strobe (regWriteOut_WB)
wb_dst  in  REG_ADDR_W  writeback destination (Destination_out_WB)
wb_data  in  DATA_W  writeback data (writeData_WB)
pc_if  in  DATA_W  fetch PC (PC_out_reg_IF)
rd_idx  in  log2(DEPTH)  read index; 0 = newest entry
rd_dst  out  REG_ADDR_W  destination of the selected entry
rd_data  out  DATA_W  data of the selected entry
rd_valid  out  1  selected entry holds a logged write
entries  out  log2(DEPTH)+1  number of valid entries, 0..DEPTH
cycle_cnt  out  CNT_W  cycles spent in RUN
retire_cnt  out  CNT_W  logged writebacks
overflow  out  1  sticky; the buffer has overwritten at least one entry
halted  out  1  sticky halt detected
state  out  2  00 IDLE, 01 RUN, 10 HALTED

Behaviour:
- All state updates on the rising edge of clk. rst and clear are synchronous, active-high. rst has priority over clear, and clear has priority over all other inputs.
- Reset/clear values: state=IDLE, all counters 0, entries=0, write pointer 0, overflow=0, halted=0, stuck counter 0, last-PC register 0, rd_dst=0, rd_data=0, rd_valid=0. Buffer contents need not be cleared, but they must be invalidated through entries.
- FSM:
  - IDLE -> RUN on the first cycle with en=1.
  - RUN -> HALTED when the stuck counter reaches HALT_CYCLES-1 while pc_if equals the last PC.
  - HALTED stays HALTED until rst or clear.
  - en=0 in RUN freezes all state, including the stuck counter, but does not leave RUN.
- Logging, in RUN with en=1:
  - A write is logged when wb_we=1 and wb_dst!=0. Writes to $zero are ignored and are not counted.
  - A logged write stores {wb_dst, wb_data} at the write pointer, increments the pointer modulo DEPTH, increments retire_cnt, and increments entries until it reaches DEPTH.
  - A logged write when entries==DEPTH overwrites the oldest entry and sets overflow.
- Counters: cycle_cnt increments every RUN cycle with en=1. Both cycle_cnt and retire_cnt saturate at all-ones and do not wrap.
- Halt detection, in RUN with en=1:
  - If pc_if equals the last PC, the stuck counter increments. Otherwise the stuck counter resets to 0.
  - The last PC register updates to pc_if every such cycle.
  - On the cycle halted is set, cycle_cnt still increments. In HALTED, counters and logging stop.
  - The first RUN cycle compares pc_if against a last PC of 0 (the reset value).
- Read port:
  - Registered, with 1-cycle latency. The rd_* outputs reflect rd_idx and the buffer state sampled at the previous edge.
  - Entry address = (write pointer - 1 - rd_idx) mod DEPTH.
  - rd_valid = (rd_idx < entries). When rd_valid=0, rd_dst and rd_data read as 0.
- Simultaneous log and read of index 0 in the same cycle returns the previous newest entry. There is no bypass.
- Reset or clear mid-run discards everything. The first edge after rst deasserts with en=1 enters RUN.

Test Plan:
- Reset/idle: rst high for 2 cycles, then en=0 for 5 cycles -> state=00, cycle_cnt=0, entries=0, rd_valid=0, all outputs 0.
- Basic logging: en=1, PC increments by 4. Writes ($8,0x5), ($9,0xA), then ($0,0xFF) -> retire_cnt=2, entries=2; rd_idx=0 returns $9/0xA and rd_idx=1 returns $8/0x5, each after 1 cycle; rd_idx=2 gives rd_valid=0.
- Wrap/overflow: DEPTH=16. Log 20 writes with dst=i%31+1 and data=i -> entries=16, overflow=1; rd_idx=0 returns data 19 and rd_idx=15 returns data 4.
- Halt: PC advances, then holds at 0x40 -> halted=1 and state=10 after exactly HALT_CYCLES=4 consecutive equal samples. After that, further wb_we pulses leave retire_cnt unchanged.
- en gating and clear: with en=0 during RUN, neither counters nor the stuck counter advance. Asserting clear for 1 cycle -> all outputs return to reset values and the next en=1 cycle reenters RUN.
- Saturation: CNT_W=4, run 20 cycles -> cycle_cnt holds at 15.

Source files
------------

// File: rtl/wb_trace_monitor.sv
// Writeback trace monitor: cycle/retire counters, circular writeback log
// with indexed read-back, and stuck-PC halt detection.
module wb_trace_monitor #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 32,
  parameter int HALT_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     wb_we,
  input  logic [REG_ADDR_W-1:0]    wb_dst,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [DATA_W-1:0]        pc_if,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [REG_ADDR_W-1:0]    rd_dst,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   entries,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic                     overflow,
  output logic                     halted,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(HALT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;

  logic [REG_ADDR_W-1:0] buf_dst  [DEPTH];
  logic [DATA_W-1:0]     buf_data [DEPTH];

  logic [AW-1:0]     wr_ptr;
  logic [SW-1:0]     stuck;
  logic [DATA_W-1:0] last_pc;

  logic          active;
  logic          log_wr;
  logic          pc_same;
  logic          stuck_hit;
  logic          full;
  logic [AW-1:0] rd_addr;
  logic          rd_hit;

  assign active    = (state == S_RUN) && en;
  assign log_wr    = active && wb_we && (wb_dst != '0);
  assign pc_same   = (pc_if == last_pc);
  // Halt fires on the compare that brings the stuck count to HALT_CYCLES-1.
  assign stuck_hit = pc_same && (stuck == SW'(HALT_CYCLES - 2));
  assign full      = (entries == (AW + 1)'(DEPTH));
  assign rd_addr   = wr_ptr - AW'(1) - rd_idx;
  assign rd_hit    = ({1'b0, rd_idx} < entries);

  // Storage is never cleared; entries alone decides what is valid.
  always_ff @(posedge clk) begin
    if (log_wr && !rst && !clear) begin
      buf_dst[wr_ptr]  <= wb_dst;
      buf_data[wr_ptr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= S_IDLE;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      entries    <= '0;
      wr_ptr     <= '0;
      overflow   <= 1'b0;
      halted     <= 1'b0;
      stuck      <= '0;
      last_pc    <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (en) state <= S_RUN;
        S_RUN: begin
          if (en) begin
            if (cycle_cnt != '1)
              cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (pc_same)
              stuck <= stuck + SW'(1);
            else
              stuck <= '0;
            last_pc <= pc_if;
            if (stuck_hit) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (log_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (retire_cnt != '1)
          retire_cnt <= retire_cnt + CNT_W'(1);
        if (full)
          overflow <= 1'b1;
        else
          entries <= entries + (AW + 1)'(1);
      end
    end
  end

  // Read port samples pre-edge buffer state: no same-cycle bypass.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_valid <= 1'b0;
      rd_dst   <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_hit;
      rd_dst   <= rd_hit ? buf_dst[rd_addr] : '0;
      rd_data  <= rd_hit ? buf_data[rd_addr] : '0;
    end
  end

endmodule
